// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root family: FSM encoding and
// width derivations, so iterative and future pipelined variants agree.
package sqrt_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      CALC = S_CALC,
      DONE = S_DONE
   } state_t;

   // Root width for a given radicand width.
   function automatic int root_w(input int width);
      return width / 2;
   endfunction

   // Working remainder width: two bits above the root covers the shifted
   // remainder before the trial subtraction on the final step.
   function automatic int rem_w(input int width);
      return width / 2 + 2;
   endfunction

   // Iteration counter width, able to hold the value RW.
   function automatic int cnt_w(input int width);
      return $clog2(width / 2 + 1);
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit step: brings in two radicand bits,
// tries subtracting (root<<2)|1 and produces the next root bit.
module sqrt_step #(
   parameter int RW = 8
) (
   input  logic [RW+1:0] rem,
   input  logic [RW-1:0] root,
   input  logic [1:0]    bits,
   output logic [RW+1:0] rem_nxt,
   output logic [RW-1:0] root_nxt
);

   logic [RW+1:0] rem_sh;
   logic [RW+1:0] trial;

   // Trial subtraction; the remainder is restored by simply not subtracting.
   always_comb begin
      rem_sh   = (rem << 2) | {{RW{1'b0}}, bits};
      trial    = {root, 2'b01};
      rem_nxt  = rem_sh;
      root_nxt = root << 1;
      if (rem_sh >= trial) begin
         rem_nxt  = rem_sh - trial;
         root_nxt = (root << 1) | {{(RW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/sqrt_iterative.sv
// Handshaked iterative integer square root: one root bit per enabled cycle,
// floor or round-to-nearest result plus the unrounded remainder.
module sqrt_iterative
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ROUND = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH/2-1:0] x_out,
   output logic [WIDTH/2:0]   rem_out
);

   localparam int RW  = root_w(WIDTH);
   localparam int REW = rem_w(WIDTH);
   localparam int CW  = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_sh;
   logic [RW-1:0]    root_q, root_nxt;
   logic [REW-1:0]   rem_q, rem_nxt;
   logic [CW-1:0]    cnt_q;
   logic [RW-1:0]    x_out_q, x_out_d;
   logic [RW:0]      rem_out_q;
   logic             accept, step, last;

   sqrt_step #(.RW(RW)) u_step (
      .rem      (rem_q),
      .root     (root_q),
      .bits     (x_sh[WIDTH-1 -: 2]),
      .rem_nxt  (rem_nxt),
      .root_nxt (root_nxt)
   );

   assign accept = (state_q == IDLE) && in_valid;
   assign step   = (state_q == CALC) && ce;
   assign last   = step && (cnt_q == CW'(1));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = CALC;
         end
         CALC: if (last) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Rounding: rem > root means x >= root^2 + root + 1, i.e. past the half
   // point. An all-ones root cannot grow, so it saturates.
   always_comb begin
      x_out_d = root_nxt;
      if (ROUND != 0 && (rem_nxt > {2'b00, root_nxt}) && !(&root_nxt))
         x_out_d = root_nxt + 1'b1;
   end

   // Datapath: load on accept, step while enabled, publish on the last step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_sh      <= '0;
         root_q    <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         x_out_q   <= '0;
         rem_out_q <= '0;
      end else if (accept) begin
         x_sh   <= x_in;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= CW'(RW);
      end else if (step) begin
         x_sh   <= x_sh << 2;
         root_q <= root_nxt;
         rem_q  <= rem_nxt;
         cnt_q  <= cnt_q - 1'b1;
         if (last) begin
            x_out_q   <= x_out_d;
            rem_out_q <= rem_nxt[RW:0];
         end
      end
   end

   assign x_out   = x_out_q;
   assign rem_out = rem_out_q;

endmodule

// File: tb/tb_sqrt_iterative.sv
// Directed bench for sqrt_iterative: floor/round variants at WIDTH=16 and a
// WIDTH=32 instance with a sweep against an independent floor-sqrt model.
module tb_sqrt_iterative;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] x16;
   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [7:0]  x_out_a, x_out_b;
   logic [8:0]  rem_out_a, rem_out_b;

   logic        in_valid_c, out_ready_c, in_ready_c, out_valid_c;
   logic [31:0] x32;
   logic [15:0] x_out_c;
   logic [16:0] rem_out_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sqrt_iterative #(.WIDTH(16), .ROUND(0)) u_a (
      .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
      .in_ready(in_ready_a), .x_in(x16), .out_valid(out_valid_a),
      .out_ready(out_ready), .x_out(x_out_a), .rem_out(rem_out_a));

   sqrt_iterative #(.WIDTH(16), .ROUND(1)) u_b (
      .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
      .in_ready(in_ready_b), .x_in(x16), .out_valid(out_valid_b),
      .out_ready(out_ready), .x_out(x_out_b), .rem_out(rem_out_b));

   sqrt_iterative #(.WIDTH(32), .ROUND(0)) u_c (
      .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid_c),
      .in_ready(in_ready_c), .x_in(x32), .out_valid(out_valid_c),
      .out_ready(out_ready_c), .x_out(x_out_c), .rem_out(rem_out_c));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Greedy bit-set floor sqrt via multiplication.
   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned r = 0;
      longint unsigned t;
      for (int b = 15; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= x) r = t;
      end
      return r;
   endfunction

   // One 16-bit operation on both ROUND variants, optional ce stall window
   // and hold cycles with out_ready low before the result is taken.
   task automatic run16(input string tag, input logic [15:0] x, input int gap_at,
                        input int gap_len, input int exp_lat, input logic [7:0] ea,
                        input logic [8:0] er, input logic [7:0] eb, input int hold);
      int cyc;
      chk({tag, " in_ready"}, in_ready_a, 1);
      x16 = x; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid_a && cyc < 200) begin
         ce = !(cyc >= gap_at && cyc < gap_at + gap_len);
         if (cyc == 2) begin in_valid = 1'b1; x16 = 16'd5; end
         else if (cyc == 3) begin in_valid = 1'b0; x16 = x; end
         tick();
         cyc++;
      end
      ce = 1'b1; in_valid = 1'b0;
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " root"}, x_out_a, ea);
      chk({tag, " rem"}, rem_out_a, er);
      chk({tag, " round root"}, x_out_b, eb);
      chk({tag, " round rem"}, rem_out_b, er);
      chk({tag, " round valid"}, out_valid_b, 1);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " hold valid"}, out_valid_a, 1);
         chk({tag, " hold root"}, x_out_a, ea);
         chk({tag, " hold rem"}, rem_out_a, er);
         chk({tag, " hold in_ready"}, in_ready_a, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " valid drop"}, out_valid_a, 0);
      chk({tag, " in_ready back"}, in_ready_a, 1);
   endtask

   task automatic run32(input string tag, input logic [31:0] x, input logic [15:0] er,
                        input logic [16:0] em, input int exp_lat);
      int cyc;
      x32 = x; in_valid_c = 1'b1;
      tick();
      in_valid_c = 1'b0;
      cyc = 0;
      while (!out_valid_c && cyc < 200) begin
         tick();
         cyc++;
      end
      if (exp_lat > 0) chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " root"}, x_out_c, er);
      chk({tag, " rem"}, rem_out_c, em);
      out_ready_c = 1'b1;
      tick();
      out_ready_c = 1'b0;
   endtask

   initial begin
      longint unsigned r;
      logic [31:0] xr;
      reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x16 = '0;
      in_valid_c = 1'b0; out_ready_c = 1'b0; x32 = '0;
      repeat (3) tick();
      chk("reset in_ready", in_ready_a, 1);
      chk("reset out_valid", out_valid_a, 0);
      chk("reset x_out", x_out_a, 0);
      chk("reset rem_out", rem_out_a, 0);
      reset_n = 1'b1;
      tick();

      run16("x18639", 16'd18639, 100, 0, 8, 8'd136, 9'd143, 8'd137, 0);
      run16("x0",     16'd0,     100, 0, 8, 8'd0,   9'd0,   8'd0,   0);
      run16("x65535", 16'd65535, 100, 0, 8, 8'd255, 9'd510, 8'd255, 0);
      run16("x2",     16'd2,     100, 0, 8, 8'd1,   9'd1,   8'd1,   0);
      run16("x3",     16'd3,     100, 0, 8, 8'd1,   9'd2,   8'd2,   0);
      run16("x56",    16'd56,    100, 0, 8, 8'd7,   9'd7,   8'd7,   0);
      run16("x57",    16'd57,    100, 0, 8, 8'd7,   9'd8,   8'd8,   0);
      run16("stall",  16'd18639, 3,   3, 11, 8'd136, 9'd143, 8'd137, 5);

      // Reset in the middle of a calculation, after a nonzero result.
      x16 = 16'd18639; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("midreset out_valid", out_valid_a, 0);
      chk("midreset x_out", x_out_a, 0);
      chk("midreset rem_out", rem_out_a, 0);
      chk("midreset in_ready", in_ready_a, 1);
      chk("midreset round x_out", x_out_b, 0);
      tick();
      reset_n = 1'b1;
      tick();
      run16("x144", 16'd144, 100, 0, 8, 8'd12, 9'd0, 8'd12, 0);

      run32("w32max", 32'hFFFF_FFFF, 16'd65535, 17'd131070, 16);
      run32("w32zero", 32'd0, 16'd0, 17'd0, 16);
      for (int i = 0; i < 1000; i++) begin
         xr = $urandom();
         r = isqrt(64'(xr));
         run32("sweep", xr, 16'(r), 17'(64'(xr) - r * r), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
